// File: rtl/regfile_pkg.sv
// Shared defaults, register-index type and busy-vector popcount for the
// integer register file and its scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_AW       = $clog2(DEF_NUM_REGS);

  // Widest busy vector the popcount helper accepts (AW+1 <= 9 bits).
  localparam int POP_MAX = 256;

  typedef logic [DEF_AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  function automatic logic [8:0] popcount(input logic [POP_MAX-1:0] vec);
    logic [8:0] n;
    n = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      n = n + 9'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector: issue sets, writeback clears (issue wins), plus the
// registered busy count and the stray-writeback pulse.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_WR   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_WR-1:0]    i_wr_en,
  input  logic [NUM_WR*AW-1:0] i_wr_sel,
  input  logic                 i_issue_en,
  input  logic [AW-1:0]        i_issue_sel,
  output logic [NUM_REGS-1:0]  o_busy,
  output logic [AW:0]          o_busy_count,
  output logic                 o_wb_stray
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_next;
  logic                stray_next;
  logic [POP_MAX-1:0]  busy_pad;
  logic [8:0]          busy_pop;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_next  = busy_q;
    stray_next = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (i_wr_en[p] && i_wr_sel[p*AW +: AW] != AW'(REG_ZERO)) begin
        if (!busy_q[i_wr_sel[p*AW +: AW]]) stray_next = 1'b1;
        busy_next[i_wr_sel[p*AW +: AW]] = 1'b0;
      end
    end
    // A new producer issued this cycle outranks the result retiring now.
    if (i_issue_en && i_issue_sel != AW'(REG_ZERO)) busy_next[i_issue_sel] = 1'b1;
    busy_next[0] = 1'b0;

    busy_pad                = '0;
    busy_pad[NUM_REGS-1:0]  = busy_next;
    busy_pop                = popcount(busy_pad);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_q       <= '0;
      o_busy_count <= '0;
      o_wb_stray   <= 1'b0;
    end else begin
      busy_q       <= busy_next;
      o_busy_count <= busy_pop[AW:0];
      o_wb_stray   <= stray_next;
    end
  end

  assign o_busy = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port integer register file (r0 hardwired to zero) with scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the reads.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_RD*AW-1:0]     i_rd_sel,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic [NUM_WR-1:0]        i_wr_en,
  input  logic [NUM_WR*AW-1:0]     i_wr_sel,
  input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
  input  logic                     i_issue_en,
  input  logic [AW-1:0]            i_issue_sel,
  output logic [AW:0]              o_busy_count,
  output logic                     o_wb_stray
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_WR   (NUM_WR),
    .AW       (AW)
  ) u_scoreboard (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_wr_en      (i_wr_en),
    .i_wr_sel     (i_wr_sel),
    .i_issue_en   (i_issue_en),
    .i_issue_sel  (i_issue_sel),
    .o_busy       (busy),
    .o_busy_count (o_busy_count),
    .o_wb_stray   (o_wb_stray)
  );

  // NOTE: the storage array is reset because reset must clear every register
  // immediately; this costs a reset net per flop, so only do it when required.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
    end else begin
      // Higher-numbered ports are visited last, so port 1 wins a conflict.
      for (int r = 1; r < NUM_REGS; r++) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (i_wr_en[p] && i_wr_sel[p*AW +: AW] == AW'(r)) begin
            regs[r] <= i_wr_data[p*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (i_rd_sel[i*AW +: AW] != AW'(REG_ZERO)) begin
        o_rd_data[i*DATA_W +: DATA_W] = regs[i_rd_sel[i*AW +: AW]];
        o_rd_busy[i]                  = busy[i_rd_sel[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        for (int p = 0; p < NUM_WR; p++) begin
          if (i_wr_en[p] && i_wr_sel[p*AW +: AW] == i_rd_sel[i*AW +: AW]) begin
            o_rd_data[i*DATA_W +: DATA_W] = i_wr_data[p*DATA_W +: DATA_W];
            o_rd_busy[i] = i_issue_en && (i_issue_sel == i_rd_sel[i*AW +: AW]);
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset, write conflict, scoreboard, stray, bypass.
module tb_reg_file_sb;

  localparam int DATA_W = 32;
  localparam int AW     = 5;

  logic              i_clk;
  logic              i_reset;
  logic [2*AW-1:0]   i_rd_sel;
  logic [2*DATA_W-1:0] o_rd_data;
  logic [1:0]        o_rd_busy;
  logic [1:0]        i_wr_en;
  logic [2*AW-1:0]   i_wr_sel;
  logic [2*DATA_W-1:0] i_wr_data;
  logic              i_issue_en;
  logic [AW-1:0]     i_issue_sel;
  logic [AW:0]       o_busy_count;
  logic              o_wb_stray;

  int checks = 0;
  int errors = 0;

  reg_file_sb dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rd_sel     (i_rd_sel),
    .o_rd_data    (o_rd_data),
    .o_rd_busy    (o_rd_busy),
    .i_wr_en      (i_wr_en),
    .i_wr_sel     (i_wr_sel),
    .i_wr_data    (i_wr_data),
    .i_issue_en   (i_issue_en),
    .i_issue_sel  (i_issue_sel),
    .o_busy_count (o_busy_count),
    .o_wb_stray   (o_wb_stray)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_wr_en    = '0;
    i_wr_sel   = '0;
    i_wr_data  = '0;
    i_issue_en = 1'b0;
    i_issue_sel = '0;
  endtask

  task automatic test_reset();
    i_reset  = 1'b1;
    idle();
    i_rd_sel = {5'd7, 5'd5};
    repeat (2) step();
    checks++; if (o_rd_data !== 64'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", o_rd_data); end
    checks++; if (o_rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy got %b want 00", o_rd_busy); end
    checks++; if (o_busy_count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d want 0", o_busy_count); end
    checks++; if (o_wb_stray !== 1'b0) begin errors++; $display("FAIL reset_stray got %b want 0", o_wb_stray); end
    i_reset = 1'b0;
  endtask

  task automatic test_reset_mid();
    i_rd_sel        = {5'd7, 5'd5};
    i_wr_en         = 2'b01;
    i_wr_sel[4:0]   = 5'd5;
    i_wr_data[31:0] = 32'hDEADBEEF;
    i_issue_en      = 1'b1;
    i_issue_sel     = 5'd7;
    step();
    idle();
    checks++; if (o_rd_data[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL mid_r5 got %h want deadbeef", o_rd_data[31:0]); end
    checks++; if (o_rd_busy !== 2'b10) begin errors++; $display("FAIL mid_busy got %b want 10", o_rd_busy); end
    checks++; if (o_busy_count !== 6'd1) begin errors++; $display("FAIL mid_count got %0d want 1", o_busy_count); end
    checks++; if (o_wb_stray !== 1'b1) begin errors++; $display("FAIL mid_stray got %b want 1", o_wb_stray); end
    #2 i_reset = 1'b1;
    #1;
    checks++; if (o_rd_data !== 64'h0) begin errors++; $display("FAIL async_rd_data got %h want 0", o_rd_data); end
    checks++; if (o_rd_busy !== 2'b00) begin errors++; $display("FAIL async_busy got %b want 00", o_rd_busy); end
    checks++; if (o_busy_count !== 6'd0) begin errors++; $display("FAIL async_count got %0d want 0", o_busy_count); end
    checks++; if (o_wb_stray !== 1'b0) begin errors++; $display("FAIL async_stray got %b want 0", o_wb_stray); end
    i_reset = 1'b0;
    step();
    checks++; if (o_rd_data !== 64'h0) begin errors++; $display("FAIL post_reset_data got %h want 0", o_rd_data); end
  endtask

  task automatic test_dual_write();
    i_wr_en   = 2'b11;
    i_wr_sel  = {5'd3, 5'd3};
    i_wr_data = {32'h22222222, 32'h11111111};
    i_rd_sel  = {5'd3, 5'd0};
    step();
    idle();
    checks++; if (o_rd_data[63:32] !== 32'h22222222) begin errors++; $display("FAIL dual_write_r3 got %h want 22222222", o_rd_data[63:32]); end
    checks++; if (o_rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL read_r0 got %h want 0", o_rd_data[31:0]); end
    step();
  endtask

  task automatic test_scoreboard();
    i_rd_sel    = {5'd0, 5'd9};
    i_issue_en  = 1'b1;
    i_issue_sel = 5'd9;
    step();
    idle();
    checks++; if (o_rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_busy_set got %b want 1", o_rd_busy[0]); end
    checks++; if (o_busy_count !== 6'd1) begin errors++; $display("FAIL sb_count_set got %0d want 1", o_busy_count); end
    i_wr_en         = 2'b01;
    i_wr_sel[4:0]   = 5'd9;
    i_wr_data[31:0] = 32'h0000CAFE;
    step();
    idle();
    checks++; if (o_rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_busy_clr got %b want 0", o_rd_busy[0]); end
    checks++; if (o_busy_count !== 6'd0) begin errors++; $display("FAIL sb_count_clr got %0d want 0", o_busy_count); end
    checks++; if (o_wb_stray !== 1'b0) begin errors++; $display("FAIL sb_no_stray got %b want 0", o_wb_stray); end
    checks++; if (o_rd_data[31:0] !== 32'h0000CAFE) begin errors++; $display("FAIL sb_data got %h want 0000cafe", o_rd_data[31:0]); end
  endtask

  task automatic test_issue_wb();
    i_rd_sel    = {5'd4, 5'd0};
    i_issue_en  = 1'b1;
    i_issue_sel = 5'd4;
    step();
    idle();
    checks++; if (o_busy_count !== 6'd1) begin errors++; $display("FAIL iw_pre_count got %0d want 1", o_busy_count); end
    i_issue_en       = 1'b1;
    i_issue_sel      = 5'd4;
    i_wr_en          = 2'b10;
    i_wr_sel[9:5]    = 5'd4;
    i_wr_data[63:32] = 32'h00000044;
    step();
    idle();
    checks++; if (o_rd_data[63:32] !== 32'h00000044) begin errors++; $display("FAIL iw_data got %h want 00000044", o_rd_data[63:32]); end
    checks++; if (o_rd_busy[1] !== 1'b1) begin errors++; $display("FAIL iw_busy got %b want 1", o_rd_busy[1]); end
    checks++; if (o_busy_count !== 6'd1) begin errors++; $display("FAIL iw_count got %0d want 1", o_busy_count); end
    checks++; if (o_wb_stray !== 1'b0) begin errors++; $display("FAIL iw_stray got %b want 0", o_wb_stray); end
    i_wr_en          = 2'b10;
    i_wr_sel[9:5]    = 5'd4;
    i_wr_data[63:32] = 32'h00000045;
    step();
    idle();
    checks++; if (o_busy_count !== 6'd0) begin errors++; $display("FAIL iw_drain_count got %0d want 0", o_busy_count); end
  endtask

  task automatic test_stray();
    i_rd_sel        = {5'd0, 5'd12};
    i_wr_en         = 2'b01;
    i_wr_sel[4:0]   = 5'd12;
    i_wr_data[31:0] = 32'h12121212;
    step();
    idle();
    checks++; if (o_wb_stray !== 1'b1) begin errors++; $display("FAIL stray_pulse got %b want 1", o_wb_stray); end
    checks++; if (o_rd_data[31:0] !== 32'h12121212) begin errors++; $display("FAIL stray_data got %h want 12121212", o_rd_data[31:0]); end
    step();
    checks++; if (o_wb_stray !== 1'b0) begin errors++; $display("FAIL stray_one_cycle got %b want 0", o_wb_stray); end
    i_rd_sel        = {5'd0, 5'd0};
    i_wr_en         = 2'b01;
    i_wr_sel[4:0]   = 5'd0;
    i_wr_data[31:0] = 32'hFFFFFFFF;
    step();
    idle();
    checks++; if (o_wb_stray !== 1'b0) begin errors++; $display("FAIL r0_stray got %b want 0", o_wb_stray); end
    checks++; if (o_rd_data[31:0] !== 32'h0) begin errors++; $display("FAIL r0_data got %h want 0", o_rd_data[31:0]); end
    checks++; if (o_busy_count !== 6'd0) begin errors++; $display("FAIL r0_count got %0d want 0", o_busy_count); end
  endtask

  task automatic test_bypass();
    i_wr_en         = 2'b01;
    i_wr_sel[4:0]   = 5'd6;
    i_wr_data[31:0] = 32'h0000600D;
    step();
    idle();
    i_rd_sel        = {5'd0, 5'd6};
    i_wr_en         = 2'b01;
    i_wr_sel[4:0]   = 5'd6;
    i_wr_data[31:0] = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    checks++; if (o_rd_data[31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_same_cycle got %h want a5a5a5a5", o_rd_data[31:0]); end
`else
    checks++; if (o_rd_data[31:0] !== 32'h0000600D) begin errors++; $display("FAIL nobypass_old got %h want 0000600d", o_rd_data[31:0]); end
`endif
    step();
    idle();
    checks++; if (o_rd_data[31:0] !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_next_cycle got %h want a5a5a5a5", o_rd_data[31:0]); end
  endtask

  initial begin
    i_rd_sel = '0;
    test_reset();
    test_reset_mid();
    test_dual_write();
    test_scoreboard();
    test_issue_wb();
    test_stray();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port register file with a per-register scoreboard, the next generation of the CPU's integer register file. It serves the decode/issue stage (reads and busy checks), the issue stage (marking a destination pending) and the writeback stage (up to `NUM_WR` results per cycle). Register 0 is hardwired to zero.

## Interface
- `DATA_W`, 32, register width in bits
- `NUM_REGS`, 32, architectural registers including r0; power of two, ≥ 4; `AW = $clog2(NUM_REGS)`
- `NUM_RD`, 2, read ports, 1..4
- `NUM_WR`, 2, write ports, 1..2
- `i_clk` in 1, single clock, all state on rising edge
- `i_reset` in 1, asynchronous, active-high reset
- `i_rd_sel` in `NUM_RD×AW`, read selects
- `o_rd_data` out `NUM_RD×DATA_W`, read data, combinational
- `o_rd_busy` out `NUM_RD`, selected register has a pending write, combinational
- `i_wr_en` in `NUM_WR`, write enables
- `i_wr_sel` in `NUM_WR×AW`, write selects
- `i_wr_data` in `NUM_WR×DATA_W`, write data
- `i_issue_en` in 1, mark `i_issue_sel` busy
- `i_issue_sel` in AW, destination being issued
- `o_busy_count` out `AW+1`, registered count of busy registers
- `o_wb_stray` out 1, registered one-cycle pulse: a write hit a non-busy register

## Operation
- Storage: registers 1..`NUM_REGS-1`. Reading r0 returns 0 and `o_rd_busy=0`.
- Writes: each enabled port with a nonzero select updates its register at the clock edge. If two ports target the same register, port 1 wins.
- Scoreboard: `busy[r]` is set at the edge when `i_issue_en && i_issue_sel==r && r!=0`. It is cleared at the edge when any enabled write targets r.
- Issue and write to the same register in one cycle: the register stays busy, because the new producer takes precedence. The data is still written.
- `o_wb_stray`: set for one cycle after any enabled write with nonzero select whose target was not busy before the edge. The write is still performed. Writes to r0 never raise it.
- `o_busy_count`: popcount of the busy vector after the edge. Updated every cycle; never exceeds `NUM_REGS-1`.
- Reads without bypass return the pre-edge storage value.

## Timing
- Read data and busy: zero latency, combinational from selects and state.
- Write: visible on reads from the cycle after the enable cycle.
- Issue: busy visible the cycle after `i_issue_en`.
- Asserting `i_reset` clears all state immediately, including mid-operation, regardless of clock: all registers 0, busy vector 0, `o_busy_count=0`, `o_wb_stray=0`. Combinational outputs then reflect cleared state (`o_rd_data=0`, `o_rd_busy=0`).
- First edge after reset deassertion operates normally. Writes and issues presented while reset is high are discarded.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - If an enabled write in the current cycle targets a read select (nonzero), `o_rd_data` returns that `i_wr_data`; port 1 wins over port 0.
  - `o_rd_busy` for that port reads 0 unless `i_issue_en` targets the same register that cycle.
- Not defined: no forwarding. Reads show pre-edge storage and busy state, and same-cycle writes become visible next cycle.

## Structure
- Package `regfile_pkg`:
  - default `DATA_W`, `NUM_REGS`
  - `reg_idx_t` (`logic [AW-1:0]`)
  - `REG_ZERO` constant
  - popcount function for the busy vector
- Sub-module `regfile_scoreboard`: owns the busy vector, issue/clear priority, `o_busy_count` and `o_wb_stray`. The top owns storage, write arbitration and read/bypass muxing.

## Test plan
- Reset mid-stream: write r5=0xDEADBEEF and issue r7, then pulse `i_reset` between edges. All reads return 0, `o_busy_count=0`, `o_wb_stray=0` immediately.
- Dual write conflict: port0 writes r3=0x11111111 and port1 writes r3=0x22222222 in the same cycle. r3 reads 0x22222222 next cycle.
- Scoreboard round-trip: issue r9, so `o_rd_busy=1` and `o_busy_count=1` next cycle. Write r9=0xCAFE, so busy=0 and count=0 next cycle, with no stray pulse.
- Simultaneous issue and writeback on r4 (already busy): r4 updates, r4 stays busy, count is unchanged.
- Stray write to non-busy r12: `o_wb_stray=1` for exactly one cycle and the data is written. Write to r0 with 0xFFFFFFFF: r0 still reads 0, no stray pulse.
- Bypass: write r6=0xA5A5A5A5 with read select r6 in the same cycle.
  - With `REGFILE_BYPASS_EN`: read returns 0xA5A5A5A5 that cycle.
  - Without it: read returns the old value, then 0xA5A5A5A5 next cycle.
